// File: rtl/cofre_pkg.sv
// rtl/cofre_pkg.sv - shared state encoding and widths for the safe lock controller
package cofre_pkg;

  localparam int CLK_HZ   = 27000000;
  localparam int W_SEG    = 6;
  localparam int W_FALHAS = 2;

  typedef enum logic [1:0] {
    FECHADO      = 2'd0,
    ABERTO       = 2'd1,
    ALERTA_PORTA = 2'd2,
    BLOQUEADO    = 2'd3
  } estado_t;

endpackage

// File: rtl/sincroniza_borda.sv
// rtl/sincroniza_borda.sv - 2-flop synchronizer with rising-edge pulse
module sincroniza_borda (
  input  logic clk_27,
  input  logic reset,
  input  logic entrada,
  output logic nivel,
  output logic pulso
);

  logic s1_q, s2_q, ant_q;

  always_ff @(posedge clk_27 or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      ant_q <= 1'b0;
    end else begin
      s1_q  <= entrada;
      s2_q  <= s1_q;
      ant_q <= s2_q;
    end
  end

  assign nivel = s2_q;
  assign pulso = s2_q & ~ant_q;

endmodule

// File: rtl/controle_trava.sv
// rtl/controle_trava.sv - lock solenoid, door alarm and brute-force lockout controller
module controle_trava
  import cofre_pkg::*;
#(
  parameter int TICK_DIV     = CLK_HZ,
  parameter int ABERTO_SEG   = 5,
  parameter int BLOQUEIO_SEG = 30,
  parameter int MAX_FALHAS   = 3
) (
  input  logic              clk_27,
  input  logic              reset,
  input  logic              aceitoID,
  input  logic              falhaID,
  input  logic              porta_aberta,
  output logic              trava_aberta,
  output logic              alarme,
  output logic              bloqueado,
  output logic [W_FALHAS-1:0] falhas,
  output logic [W_SEG-1:0]  segundos_restantes
);

  localparam int W_PRE = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W_PRE-1:0]    PRE_MAX    = W_PRE'(TICK_DIV - 1);
  localparam logic [W_SEG-1:0]    SEG_ABERTO = W_SEG'(ABERTO_SEG);
  localparam logic [W_SEG-1:0]    SEG_BLOQ   = W_SEG'(BLOQUEIO_SEG);
  localparam logic [W_FALHAS-1:0] FALHAS_MAX = W_FALHAS'(MAX_FALHAS);

  if (TICK_DIV < 1) begin : g_erro_tick
    $error("TICK_DIV must be at least 1");
  end
  if (ABERTO_SEG < 1 || ABERTO_SEG > 63) begin : g_erro_aberto
    $error("ABERTO_SEG out of range 1..63");
  end
  if (BLOQUEIO_SEG < 1 || BLOQUEIO_SEG > 63) begin : g_erro_bloqueio
    $error("BLOQUEIO_SEG out of range 1..63");
  end
  if (MAX_FALHAS < 1 || MAX_FALHAS > 3) begin : g_erro_falhas
    $error("MAX_FALHAS out of range 1..3");
  end

  logic ok_nivel, ok_pulso, falha_nivel, falha_pulso, porta_nivel, porta_pulso;
  logic unused_sinais;

  sincroniza_borda u_sinc_ok (
    .clk_27(clk_27), .reset(reset), .entrada(aceitoID), .nivel(ok_nivel), .pulso(ok_pulso)
  );
  sincroniza_borda u_sinc_falha (
    .clk_27(clk_27), .reset(reset), .entrada(falhaID), .nivel(falha_nivel), .pulso(falha_pulso)
  );
  sincroniza_borda u_sinc_porta (
    .clk_27(clk_27), .reset(reset), .entrada(porta_aberta), .nivel(porta_nivel), .pulso(porta_pulso)
  );

  assign unused_sinais = ^{ok_nivel, falha_nivel, porta_pulso};

  estado_t               estado_q, estado_d;
  logic [W_PRE-1:0]      pre_q, pre_d;
  logic [W_SEG-1:0]      seg_q, seg_d;
  logic [W_FALHAS-1:0]   falhas_q, falhas_d, falhas_inc;
  logic                  trava_q, alarme_q, bloq_q;
  logic                  tick, entra_temporizado;

  assign tick       = (pre_q == PRE_MAX);
  assign falhas_inc = (falhas_q == FALHAS_MAX) ? falhas_q : falhas_q + 1'b1;

  always_comb begin
    estado_d = estado_q;
    seg_d    = seg_q;
    falhas_d = falhas_q;
    case (estado_q)
      FECHADO: begin
        // A simultaneous accept and reject counts only as a failure.
        if (falha_pulso) begin
          falhas_d = falhas_inc;
          if (falhas_inc == FALHAS_MAX) begin
            estado_d = BLOQUEADO;
            seg_d    = SEG_BLOQ;
          end
        end else if (ok_pulso) begin
          estado_d = ABERTO;
          falhas_d = '0;
          seg_d    = SEG_ABERTO;
        end
      end
      ABERTO: begin
        if (tick && seg_q != '0) begin
          seg_d = seg_q - 1'b1;
          if (seg_q == W_SEG'(1)) estado_d = porta_nivel ? ALERTA_PORTA : FECHADO;
        end
      end
      ALERTA_PORTA: begin
        seg_d = '0;
        if (!porta_nivel) estado_d = FECHADO;
      end
      BLOQUEADO: begin
        if (tick && seg_q != '0) begin
          seg_d = seg_q - 1'b1;
          if (seg_q == W_SEG'(1)) begin
            estado_d = FECHADO;
            falhas_d = '0;
          end
        end
      end
    endcase
  end

  // Restarting the prescaler on entry makes a timed state last exactly N ticks.
  assign entra_temporizado = (estado_d != estado_q) &&
                             (estado_d == ABERTO || estado_d == BLOQUEADO);

  always_comb begin
    pre_d = pre_q + 1'b1;
    if (entra_temporizado || tick) pre_d = '0;
  end

  always_ff @(posedge clk_27 or posedge reset) begin
    if (reset) begin
      estado_q <= FECHADO;
      pre_q    <= '0;
      seg_q    <= '0;
      falhas_q <= '0;
      trava_q  <= 1'b0;
      alarme_q <= 1'b0;
      bloq_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pre_q    <= pre_d;
      seg_q    <= seg_d;
      falhas_q <= falhas_d;
      trava_q  <= (estado_d == ABERTO);
      alarme_q <= (estado_d == ALERTA_PORTA) || (estado_d == BLOQUEADO);
      bloq_q   <= (estado_d == BLOQUEADO);
    end
  end

  assign trava_aberta       = trava_q;
  assign alarme             = alarme_q;
  assign bloqueado          = bloq_q;
  assign falhas             = falhas_q;
  assign segundos_restantes = seg_q;

endmodule

// File: tb/tb_controle_trava.sv
// tb/tb_controle_trava.sv - scoreboard bench for controle_trava with a deadline-based reference model
module tb_controle_trava;

  localparam int TD = 10;
  localparam int AS = 3;
  localparam int BS = 5;
  localparam int MF = 3;

  localparam int M_FECH = 0;
  localparam int M_ABER = 1;
  localparam int M_ALER = 2;
  localparam int M_BLOQ = 3;

  logic       clk_27 = 1'b0;
  logic       reset = 1'b1;
  logic       aceitoID = 1'b0;
  logic       falhaID = 1'b0;
  logic       porta_aberta = 1'b0;
  logic       trava_aberta, alarme, bloqueado;
  logic [1:0] falhas;
  logic [5:0] segundos_restantes;

  typedef struct packed {
    logic       trava;
    logic       alarme;
    logic       bloq;
    logic [1:0] falhas;
    logic [5:0] seg;
  } saida_t;

  saida_t esperado_q[$];
  int checks = 0;
  int failures = 0;

  controle_trava #(
    .TICK_DIV(TD), .ABERTO_SEG(AS), .BLOQUEIO_SEG(BS), .MAX_FALHAS(MF)
  ) dut (
    .clk_27(clk_27),
    .reset(reset),
    .aceitoID(aceitoID),
    .falhaID(falhaID),
    .porta_aberta(porta_aberta),
    .trava_aberta(trava_aberta),
    .alarme(alarme),
    .bloqueado(bloqueado),
    .falhas(falhas),
    .segundos_restantes(segundos_restantes)
  );

  always #5 clk_27 = ~clk_27;

  // Reference model: a mode plus an absolute deadline (in edges) for the timed modes.
  int m_modo = M_FECH;
  int m_falhas = 0;
  int m_prazo = 0;
  int m_ciclo = 0;
  bit ha[3];
  bit hf[3];
  bit hd[2];
  bit pok, pf, porta;

  function automatic saida_t saida_modelo();
    saida_t s;
    s.trava  = (m_modo == M_ABER);
    s.alarme = (m_modo == M_ALER) || (m_modo == M_BLOQ);
    s.bloq   = (m_modo == M_BLOQ);
    s.falhas = 2'(m_falhas);
    if (m_modo == M_ABER || m_modo == M_BLOQ)
      s.seg = 6'((m_prazo - m_ciclo + TD - 1) / TD);
    else
      s.seg = 6'd0;
    return s;
  endfunction

  always @(posedge clk_27 or posedge reset) begin
    if (reset) begin
      m_modo   = M_FECH;
      m_falhas = 0;
      ha = '{0, 0, 0};
      hf = '{0, 0, 0};
      hd = '{0, 0};
      esperado_q.delete();
      esperado_q.push_back('0);
    end else begin
      m_ciclo++;
      pok   = ha[1] && !ha[2];
      pf    = hf[1] && !hf[2];
      porta = hd[1];
      ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = aceitoID;
      hf[2] = hf[1]; hf[1] = hf[0]; hf[0] = falhaID;
      hd[1] = hd[0]; hd[0] = porta_aberta;
      case (m_modo)
        M_FECH: begin
          if (pf) begin
            m_falhas = (m_falhas + 1 > MF) ? MF : m_falhas + 1;
            if (m_falhas == MF) begin
              m_modo  = M_BLOQ;
              m_prazo = m_ciclo + TD * BS;
            end
          end else if (pok) begin
            m_falhas = 0;
            m_modo   = M_ABER;
            m_prazo  = m_ciclo + TD * AS;
          end
        end
        M_ABER: if (m_ciclo == m_prazo) m_modo = porta ? M_ALER : M_FECH;
        M_ALER: if (!porta) m_modo = M_FECH;
        default: if (m_ciclo == m_prazo) begin
          m_modo   = M_FECH;
          m_falhas = 0;
        end
      endcase
      esperado_q.push_back(saida_modelo());
    end
  end

  saida_t atual, esp;

  always @(negedge clk_27) begin
    atual = {trava_aberta, alarme, bloqueado, falhas, segundos_restantes};
    checks++;
    if (esperado_q.size() == 0) begin
      failures++;
      $display("FAIL fila_vazia t=%0t no expected value queued", $time);
    end else begin
      esp = esperado_q.pop_front();
      if (atual !== esp) begin
        failures++;
        $display("FAIL saidas t=%0t trava=%b/%b alarme=%b/%b bloq=%b/%b falhas=%0d/%0d seg=%0d/%0d (got/expected)",
                 $time, atual.trava, esp.trava, atual.alarme, esp.alarme, atual.bloq, esp.bloq,
                 atual.falhas, esp.falhas, atual.seg, esp.seg);
      end
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk_27);
  endtask

  task automatic pulso_aceito();
    aceitoID = 1'b1; ciclos(2); aceitoID = 1'b0; ciclos(3);
  endtask

  task automatic pulso_falha();
    falhaID = 1'b1; ciclos(2); falhaID = 1'b0; ciclos(3);
  endtask

  task automatic reset_assinc();
    @(posedge clk_27);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({trava_aberta, alarme, bloqueado, falhas, segundos_restantes} !== 11'd0) begin
      failures++;
      $display("FAIL reset_imediato t=%0t outputs=%b expected all zero", $time,
               {trava_aberta, alarme, bloqueado, falhas, segundos_restantes});
    end
    ciclos(2);
    reset = 1'b0;
  endtask

  initial begin
    ciclos(3);
    reset = 1'b0;
    ciclos(2);

    aceitoID = 1'b1; ciclos(40); aceitoID = 1'b0; ciclos(5);

    porta_aberta = 1'b1; pulso_aceito(); ciclos(40);
    porta_aberta = 1'b0; ciclos(6);

    repeat (3) pulso_falha();
    ciclos(10); pulso_aceito(); ciclos(50);

    repeat (2) pulso_falha();
    pulso_aceito(); ciclos(40);
    pulso_falha(); ciclos(10);

    aceitoID = 1'b1; falhaID = 1'b1; ciclos(3);
    aceitoID = 1'b0; falhaID = 1'b0; ciclos(5);

    reset_assinc(); ciclos(2);
    aceitoID = 1'b1; ciclos(2); aceitoID = 1'b0; ciclos(15);
    reset_assinc(); ciclos(3); pulso_aceito(); ciclos(40);

    repeat (3) pulso_falha();
    ciclos(20); reset_assinc(); ciclos(3); pulso_aceito(); ciclos(40);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)   aceitoID = ~aceitoID;
      if ($urandom_range(7) == 0)   falhaID = ~falhaID;
      if ($urandom_range(15) == 0)  porta_aberta = ~porta_aberta;
      if ($urandom_range(499) == 0) reset_assinc();
      ciclos(1);
    end
    ciclos(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog t=%0t bench did not complete", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/controle_trava.md
Name: controle_trava

Overview:
- Downstream stage of the safe's ID/password checker.
- Consumes the checker's `aceitoID`/`falhaID` result levels and drives the lock solenoid, a door-open alarm and a brute-force lockout.
- Counts consecutive failures; after `MAX_FALHAS` failures it locks out new attempts for a timed period and drives `bloqueado` back to the checker.
- All timing is derived from `clk_27` through an internal 1-second tick prescaler.

Parameters:
- `TICK_DIV`, 27000000, clk_27 cycles per second tick (sim benches use 10).
- `ABERTO_SEG`, 5, seconds the lock stays released after acceptance; range 1..63.
- `BLOQUEIO_SEG`, 30, lockout duration in seconds; range 1..63.
- `MAX_FALHAS`, 3, consecutive failures that trigger lockout; range 1..3.

Ports:
- `clk_27` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `aceitoID` input 1: checker accept level; asynchronous to this block.
- `falhaID` input 1: checker reject level; asynchronous to this block.
- `porta_aberta` input 1: door sensor, 1 = door open; asynchronous.
- `trava_aberta` output 1: solenoid drive, 1 = lock released.
- `alarme` output 1: alarm LED/buzzer.
- `bloqueado` output 1: 1 = lockout active; the checker must not accept entries.
- `falhas` output 2: current consecutive-failure count.
- `segundos_restantes` output 6: seconds left in the active timed state; 0 otherwise.

Behaviour:
- Reset (asynchronous, any state, any time): state=FECHADO, outputs `trava_aberta`=0, `alarme`=0, `bloqueado`=0, `falhas`=0, `segundos_restantes`=0; prescaler=0, synchronizers=0. A reset while the lock is open closes it immediately.
- Input conditioning:
  - `aceitoID`, `falhaID` and `porta_aberta` each pass through a 2-flop synchronizer.
  - `aceitoID` and `falhaID` are then rising-edge detected into 1-cycle pulses `p_ok` and `p_falha`.
  - Levels held high never re-trigger.
  - Latency: input high before rising edge k gives a pulse during cycle k+1; the state/outputs update at edge k+2. All outputs are registered.
- Tick:
  - The prescaler counts 0..TICK_DIV-1; `tick` is asserted on the cycle it wraps.
  - The prescaler is cleared on every entry to ABERTO or BLOQUEADO, so timed states last exactly N*TICK_DIV cycles.
- States:
  - FECHADO:
    - `p_ok` -> ABERTO, `falhas`=0, `segundos_restantes`=ABERTO_SEG.
    - `p_falha` -> `falhas`+1; if the new value == MAX_FALHAS -> BLOQUEADO, `segundos_restantes`=BLOQUEIO_SEG.
    - `p_ok` and `p_falha` in the same cycle -> treated as a failure only.
  - ABERTO:
    - `trava_aberta`=1.
    - Each tick decrements `segundos_restantes`.
    - On the tick that takes it 1->0: if synced `porta_aberta`=1 go to ALERTA_PORTA, else go to FECHADO.
    - Pulses are ignored (no count change).
  - ALERTA_PORTA:
    - `trava_aberta`=0, `alarme`=1, `segundos_restantes`=0.
    - Synced `porta_aberta`=0 -> FECHADO.
    - Pulses are ignored.
  - BLOQUEADO:
    - `bloqueado`=1, `alarme`=1, `trava_aberta`=0.
    - `segundos_restantes` decrements per tick; on 1->0 go to FECHADO with `falhas`=0.
    - Pulses are ignored.
- Width rules:
  - `segundos_restantes` is a 6-bit down-counter and never wraps below 0.
  - `falhas` saturates at MAX_FALHAS and is cleared on exit from BLOQUEADO or on acceptance.
- Elaboration checks: out-of-range parameters (ABERTO_SEG or BLOQUEIO_SEG outside 1..63, MAX_FALHAS outside 1..3) are an elaboration error.
- `porta_aberta` during FECHADO has no effect; no alarm is raised.

Decomposition:
- Shared package `cofre_pkg`:
  - state encoding localparams FECHADO=2'd0, ABERTO=2'd1, ALERTA_PORTA=2'd2, BLOQUEADO=2'd3;
  - CLK_HZ=27000000;
  - widths W_SEG=6 and W_FALHAS=2.
- One sub-module `sincroniza_borda`:
  - contains the 2-flop synchronizer plus a rising-edge register;
  - outputs `nivel` (synced level) and `pulso` (edge pulse);
  - instantiated three times (`porta_aberta` uses only `nivel`).
- Prescaler, FSM and counters live in `controle_trava`.

Test Plan (TICK_DIV=10, ABERTO_SEG=3, BLOQUEIO_SEG=5, MAX_FALHAS=3):
1. Acceptance: raise `aceitoID` and hold -> `trava_aberta`=1 at edge k+2 for exactly 30 cycles, `segundos_restantes` 3,2,1,0 every 10 cycles -> FECHADO; holding `aceitoID` high causes no reopen.
2. Door left open: accept with `porta_aberta`=1 through timeout -> `trava_aberta`=0, `alarme`=1; drop `porta_aberta` -> `alarme`=0 three cycles later.
3. Lockout: three `falhaID` rise/fall cycles -> `falhas`=1,2, then `bloqueado`=1, `alarme`=1 for 50 cycles; `aceitoID` pulse during lockout ignored; afterwards `falhas`=0, `bloqueado`=0.
4. Failure reset: two failures then one acceptance -> `falhas`=0 and lock opens; a third failure later gives `falhas`=1, no lockout.
5. Simultaneous: `aceitoID` and `falhaID` rise on the same edge in FECHADO -> `falhas`+1, `trava_aberta` stays 0.
6. Reset mid-operation: assert `reset` 15 cycles into ABERTO and mid-BLOQUEADO, off-clock-edge -> all outputs 0 immediately; next acceptance after release opens for a full 30 cycles.
